// File: rtl/alt_vipcti_common_sync_filter.sv
// N-stage bus synchroniser followed by a stability filter that commits a value only after it has held steady.
// Optional per-bit rise/fall markers are built when ALT_VIPCTI_SYNC_EDGE_DET_EN is defined.
module alt_vipcti_common_sync_filter #(
  parameter int                CLOCKS_ARE_SAME = 0,
  parameter int                WIDTH           = 1,
  parameter int                STAGES          = 2,
  parameter int                STABLE_CYCLES   = 0,
  parameter logic [WIDTH-1:0]  RESET_VALUE     = '0
) (
  input  logic             sync_clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             update_pulse,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             settling
);

  logic [WIDTH-1:0] s;

  // ---- synchroniser stage: data_in -> stage0 -> ... -> s ----
  generate
    if (CLOCKS_ARE_SAME != 0) begin : g_same
      assign s = data_in;
    end else begin : g_sync
      (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS; -name DONT_MERGE_REGISTER ON; -name PRESERVE_REGISTER ON; -name SDC_STATEMENT {set_false_path -to [get_keepers {*alt_vipcti_common_sync_filter*sync_stage0*}]}" *)
      logic [WIDTH-1:0] sync_stage0;
      (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS; -name DONT_MERGE_REGISTER ON; -name PRESERVE_REGISTER ON" *)
      logic [WIDTH-1:0] sync_chain [1:STAGES-1];

      always_ff @(posedge sync_clock or negedge rst_n) begin
        if (!rst_n) begin
          sync_stage0 <= RESET_VALUE;
          for (int i = 1; i < STAGES; i++) sync_chain[i] <= RESET_VALUE;
        end else begin
          sync_stage0   <= data_in;
          sync_chain[1] <= sync_stage0;
          for (int i = 2; i < STAGES; i++) sync_chain[i] <= sync_chain[i-1];
        end
      end

      assign s = sync_chain[STAGES-1];
    end
  endgenerate

  // ---- filter stage ----
  generate
    if (STABLE_CYCLES == 0) begin : g_bypass
      logic [WIDTH-1:0] s_d;

      always_ff @(posedge sync_clock or negedge rst_n) begin
        if (!rst_n) s_d <= RESET_VALUE;
        else        s_d <= s;
      end

      assign data_out     = s;
      assign update_pulse = (s != s_d);
      assign settling     = 1'b0;
`ifdef ALT_VIPCTI_SYNC_EDGE_DET_EN
      // s_d already holds the pre-change value, so it doubles as prev here.
      assign rise_pulse = update_pulse ? (s & ~s_d) : '0;
      assign fall_pulse = update_pulse ? (~s & s_d) : '0;
`else
      assign rise_pulse = '0;
      assign fall_pulse = '0;
`endif
    end else begin : g_filter
      localparam int             CNT_W   = $clog2(STABLE_CYCLES + 1);
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
      localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

      typedef enum logic {IDLE = 1'b0, SETTLE = 1'b1} state_t;

      state_t           state, state_nxt;
      logic [WIDTH-1:0] cand, cand_nxt;
      logic [WIDTH-1:0] data_q, data_nxt;
      logic [CNT_W-1:0] cnt, cnt_nxt;
      logic             upd, upd_nxt;

      always_ff @(posedge sync_clock or negedge rst_n) begin
        if (!rst_n) begin
          state  <= IDLE;
          cand   <= RESET_VALUE;
          data_q <= RESET_VALUE;
          cnt    <= '0;
          upd    <= 1'b0;
        end else begin
          state  <= state_nxt;
          cand   <= cand_nxt;
          data_q <= data_nxt;
          cnt    <= cnt_nxt;
          upd    <= upd_nxt;
        end
      end

      always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        data_nxt  = data_q;
        cnt_nxt   = cnt;
        upd_nxt   = 1'b0;
        case (state)
          IDLE: begin
            if (s != data_q) begin
              cand_nxt  = s;
              cnt_nxt   = CNT_ONE;
              state_nxt = SETTLE;
            end
          end
          SETTLE: begin
            // Return-to-old beats restart beats commit: a glitch that reverts never fires.
            if (s == data_q) begin
              state_nxt = IDLE;
              cnt_nxt   = '0;
            end else if (s != cand) begin
              cand_nxt = s;
              cnt_nxt  = CNT_ONE;
            end else if (cnt == CNT_MAX) begin
              data_nxt  = cand;
              upd_nxt   = 1'b1;
              cnt_nxt   = '0;
              state_nxt = IDLE;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end

      assign data_out     = data_q;
      assign update_pulse = upd;
      assign settling     = (state == SETTLE);

`ifdef ALT_VIPCTI_SYNC_EDGE_DET_EN
      logic [WIDTH-1:0] prev;

      always_ff @(posedge sync_clock or negedge rst_n) begin
        if (!rst_n)       prev <= RESET_VALUE;
        else if (upd_nxt) prev <= data_q;
      end

      assign rise_pulse = upd ? (data_q & ~prev) : '0;
      assign fall_pulse = upd ? (~data_q & prev) : '0;
`else
      assign rise_pulse = '0;
      assign fall_pulse = '0;
`endif
    end
  endgenerate

endmodule
